// File: rtl/sparc_muldiv_pkg.sv
// Shared op3 encodings, FSM state encoding and saturation constants for the
// SPARC multiply/divide unit.
package sparc_muldiv_pkg;
  localparam logic [5:0] OP_UMUL   = 6'b001010;
  localparam logic [5:0] OP_SMUL   = 6'b001011;
  localparam logic [5:0] OP_UDIV   = 6'b001110;
  localparam logic [5:0] OP_SDIV   = 6'b001111;
  localparam logic [5:0] OP_UMULCC = 6'b011010;
  localparam logic [5:0] OP_SMULCC = 6'b011011;
  localparam logic [5:0] OP_UDIVCC = 6'b011110;
  localparam logic [5:0] OP_SDIVCC = 6'b011111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Saturation words are built wide and sliced to WIDTH by the user.
  localparam int SAT_MAX_W = 128;

  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int w);
    return SAT_MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int w);
    return sat_neg(w) - SAT_MAX_W'(1);
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_UMUL, OP_SMUL, OP_UDIV, OP_SDIV,
                      OP_UMULCC, OP_SMULCC, OP_UDIVCC, OP_SDIVCC};
  endfunction
endpackage

// File: rtl/sparc_muldiv_if.sv
// Request/response bundle between the integer pipeline and the mul/div unit.
interface sparc_muldiv_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [5:0]       Opcode;
  logic [WIDTH-1:0] Operand1, Operand2, Y_In;
  logic             Busy, Done;
  logic [WIDTH-1:0] Result, Y_Out;
  logic             Y_Write, Div_Zero, CC_Write;
  logic             Condition_N, Condition_Z, Condition_V, Condition_C;

  modport master (output Start, Opcode, Operand1, Operand2, Y_In,
                  input  Busy, Done, Result, Y_Out, Y_Write, Div_Zero, CC_Write,
                         Condition_N, Condition_Z, Condition_V, Condition_C);
  modport slave  (input  Start, Opcode, Operand1, Operand2, Y_In,
                  output Busy, Done, Result, Y_Out, Y_Write, Div_Zero, CC_Write,
                         Condition_N, Condition_Z, Condition_V, Condition_C);
endinterface

// File: rtl/sparc_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate: magnitude on the way in, sign
// restoration on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/sparc_muldiv_unit.sv
// Iterative UMUL/SMUL/UDIV/SDIV (+cc) unit, one bit per clock.
// Define MULDIV_EARLY_OUT_EN to let multiplies exit once the multiplier is exhausted.
module sparc_muldiv_unit
  import sparc_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          Clk,
  input  logic          Reset,
  sparc_muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam logic [SAT_MAX_W-1:0] SAT_POS_F = sat_pos(WIDTH);
  localparam logic [SAT_MAX_W-1:0] SAT_NEG_F = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS = SAT_POS_F[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG = SAT_NEG_F[WIDTH-1:0];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic div_q, div_d, sgn_q, sgn_d, cc_q, cc_d, neg_q, neg_d;
  logic dz_q, dz_d, ovf_q, ovf_d;
  logic done_q, done_d, ywr_q, ywr_d, dzo_q, dzo_d, ccw_q, ccw_d;
  logic n_q, n_d, z_q, z_d, v_q, v_d;
  logic [WIDTH-1:0] result_q, result_d, yout_q, yout_d;

  // Input conditioning: operand magnitudes straight off the bus.
  logic             in_div, in_sgn, in_neg1, in_neg2, accept;
  logic [W2-1:0]    in_dvd, in_mag1;
  logic [WIDTH-1:0] in_mag2;

  assign in_div  = bus.Opcode[2];
  assign in_sgn  = bus.Opcode[0];
  assign in_dvd  = in_div ? {bus.Y_In, bus.Operand1} : {{WIDTH{1'b0}}, bus.Operand1};
  assign in_neg1 = in_sgn & (in_div ? bus.Y_In[WIDTH-1] : bus.Operand1[WIDTH-1]);
  assign in_neg2 = in_sgn & bus.Operand2[WIDTH-1];
  assign accept  = bus.Start && (state_q == ST_IDLE) && op_supported(bus.Opcode);

  muldiv_sign_fix #(.W(W2))    u_fix_op1 (.val(in_dvd),       .neg(in_neg1), .res(in_mag1));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_op2 (.val(bus.Operand2), .neg(in_neg2), .res(in_mag2));

  // Restoring step: acc holds {remainder, dividend low}; quotient bits fill from the bottom.
  logic [WIDTH:0]   dv_sub;
  logic [W2-1:0]    div_step;
  assign dv_sub   = acc_q[W2-1:WIDTH-1] - {1'b0, mplier_q};
  assign div_step = dv_sub[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                  : {dv_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [W2-1:0] fin_in, fin_val;
  logic          q_ovf;
  assign fin_in = div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
  assign q_ovf  = sgn_q & (neg_q ? (acc_q[WIDTH-1:0] > SAT_NEG) : acc_q[WIDTH-1]);

  muldiv_sign_fix #(.W(W2)) u_fix_fin (.val(fin_in), .neg(neg_q), .res(fin_val));

  logic [WIDTH-1:0] res;
  logic             v;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  acc_d = acc_q;  mcand_d = mcand_q;
    mplier_d = mplier_q;  div_d = div_q;  sgn_d = sgn_q;  cc_d = cc_q;  neg_d = neg_q;
    dz_d = dz_q;  ovf_d = ovf_q;
    done_d = 1'b0;  ywr_d = 1'b0;  dzo_d = 1'b0;  ccw_d = 1'b0;
    n_d = n_q;  z_d = z_q;  v_d = v_q;
    result_d = result_q;  yout_d = yout_q;
    res = '0;  v = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        div_d    = in_div;
        sgn_d    = in_sgn;
        cc_d     = bus.Opcode[4];
        neg_d    = in_neg1 ^ in_neg2;
        cnt_d    = '0;
        dz_d     = in_div && (bus.Operand2 == '0);
        ovf_d    = in_div && !dz_d && (in_mag1[W2-1:WIDTH] >= in_mag2);
        mplier_d = in_mag2;
        acc_d    = in_div ? in_mag1 : '0;
        mcand_d  = {{WIDTH{1'b0}}, in_mag1[WIDTH-1:0]};
        state_d  = (dz_d || ovf_d) ? ST_FIN : ST_RUN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!in_div && (in_mag2 == '0)) state_d = ST_FIN;
`endif
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) acc_d = div_step;
        else begin
          acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!div_q && (mplier_d == '0)) state_d = ST_FIN;
`endif
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ccw_d   = cc_q;
        ywr_d   = !div_q;
        dzo_d   = dz_q;
        if (!div_q) begin
          res    = fin_val[WIDTH-1:0];
          yout_d = fin_val[W2-1:WIDTH];
        end else if (dz_q) begin
          res = '0;
        end else if (ovf_q || q_ovf) begin
          res = !sgn_q ? '1 : (neg_q ? SAT_NEG : SAT_POS);
          v   = 1'b1;
        end else begin
          res = fin_val[WIDTH-1:0];
        end
        result_d = res;
        if (cc_q) begin
          n_d = res[WIDTH-1];
          z_d = (res == '0);
          v_d = v;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  acc_q <= '0;  mcand_q <= '0;  mplier_q <= '0;
      div_q <= 1'b0;  sgn_q <= 1'b0;  cc_q <= 1'b0;  neg_q <= 1'b0;
      dz_q <= 1'b0;  ovf_q <= 1'b0;
      done_q <= 1'b0;  ywr_q <= 1'b0;  dzo_q <= 1'b0;  ccw_q <= 1'b0;
      n_q <= 1'b0;  z_q <= 1'b0;  v_q <= 1'b0;
      result_q <= '0;  yout_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  acc_q <= acc_d;  mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      div_q <= div_d;  sgn_q <= sgn_d;  cc_q <= cc_d;  neg_q <= neg_d;
      dz_q <= dz_d;  ovf_q <= ovf_d;
      done_q <= done_d;  ywr_q <= ywr_d;  dzo_q <= dzo_d;  ccw_q <= ccw_d;
      n_q <= n_d;  z_q <= z_d;  v_q <= v_d;
      result_q <= result_d;  yout_q <= yout_d;
    end
  end

  assign bus.Busy        = (state_q != ST_IDLE);
  assign bus.Done        = done_q;
  assign bus.Result      = result_q;
  assign bus.Y_Out       = yout_q;
  assign bus.Y_Write     = ywr_q;
  assign bus.Div_Zero    = dzo_q;
  assign bus.CC_Write    = ccw_q;
  assign bus.Condition_N = n_q;
  assign bus.Condition_Z = z_q;
  assign bus.Condition_V = v_q;
  assign bus.Condition_C = 1'b0;
endmodule

// File: tb/tb_sparc_muldiv_unit.sv
// Directed bench for sparc_muldiv_unit: hand-computed results, latencies,
// handshake and reset behaviour.
module tb_sparc_muldiv_unit;
  import sparc_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  sparc_muldiv_if #(.WIDTH(32)) bus ();

  sparc_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drive a request for one cycle, then scramble the operand inputs.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] y);
    bus.Start = 1'b1;  bus.Opcode = op;  bus.Operand1 = a;  bus.Operand2 = b;  bus.Y_In = y;
    @(negedge clk);
    cyc = 1;
    bus.Start = 1'b0;  bus.Operand1 = ~a;  bus.Operand2 = b ^ 32'h5A5A_0001;  bus.Y_In = ~y;
  endtask

  task automatic wait_done();
    while (bus.Done !== 1'b1 && cyc < 100) tick();
  endtask

  function automatic logic [3:0] nzvc();
    return {bus.Condition_N, bus.Condition_Z, bus.Condition_V, bus.Condition_C};
  endfunction

  function automatic int mul_lat(input logic [31:0] m);
    int k;
    k = 32;
`ifdef MULDIV_EARLY_OUT_EN
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`else
    if (m === 32'hx) k = 0;
`endif
    return k + 2;
  endfunction

  initial begin
    int dn;
    bus.Start = 1'b0;  bus.Opcode = '0;  bus.Operand1 = '0;  bus.Operand2 = '0;  bus.Y_In = '0;
    repeat (3) @(negedge clk);
    chk("rst_done",   64'(bus.Done), 64'(0));
    chk("rst_busy",   64'(bus.Busy), 64'(0));
    chk("rst_result", 64'(bus.Result), 64'(0));
    chk("rst_yout",   64'(bus.Y_Out), 64'(0));
    chk("rst_pulses", 64'({nzvc(), bus.Y_Write, bus.Div_Zero, bus.CC_Write}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // UMUL max * max
    start_op(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk("umul_busy", 64'(bus.Busy), 64'(1));
    wait_done();
    chk("umul_lat",    64'(cyc), 64'(mul_lat(32'hFFFF_FFFF)));
    chk("umul_busy_done", 64'(bus.Busy), 64'(0));
    chk("umul_result", 64'(bus.Result), 64'(32'h0000_0001));
    chk("umul_yout",   64'(bus.Y_Out), 64'(32'hFFFF_FFFE));
    chk("umul_ywr",    64'(bus.Y_Write), 64'(1));
    chk("umul_ccw",    64'(bus.CC_Write), 64'(0));

    // SMULcc -3 * 5
    start_op(OP_SMULCC, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0);
    wait_done();
    chk("smul_lat",    64'(cyc), 64'(mul_lat(32'h5)));
    chk("smul_result", 64'(bus.Result), 64'(32'hFFFF_FFF1));
    chk("smul_yout",   64'(bus.Y_Out), 64'(32'hFFFF_FFFF));
    chk("smul_nzvc",   64'(nzvc()), 64'(4'b1000));
    chk("smul_ccw",    64'(bus.CC_Write), 64'(1));

    // UDIVcc 100 / 7
    start_op(OP_UDIVCC, 32'd100, 32'd7, 32'h0);
    wait_done();
    chk("udiv_lat",    64'(cyc), 64'(34));
    chk("udiv_result", 64'(bus.Result), 64'(32'h0000_000E));
    chk("udiv_nzvc",   64'(nzvc()), 64'(4'b0000));
    chk("udiv_ywr",    64'(bus.Y_Write), 64'(0));
    chk("udiv_dz",     64'(bus.Div_Zero), 64'(0));

    // SDIV -7 / 2 truncates toward zero; non-cc keeps flags
    start_op(OP_SDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    wait_done();
    chk("sdiv_lat",    64'(cyc), 64'(34));
    chk("sdiv_result", 64'(bus.Result), 64'(32'hFFFF_FFFD));
    chk("sdiv_ccw",    64'(bus.CC_Write), 64'(0));
    chk("sdiv_nzvc",   64'(nzvc()), 64'(4'b0000));

    // UDIVcc overflow fast path
    start_op(OP_UDIVCC, 32'h0, 32'h1, 32'h1);
    wait_done();
    chk("uovf_lat",    64'(cyc), 64'(2));
    chk("uovf_result", 64'(bus.Result), 64'(32'hFFFF_FFFF));
    chk("uovf_nzvc",   64'(nzvc()), 64'(4'b1010));

    // SDIVcc 2^31 / 1 saturates positive
    start_op(OP_SDIVCC, 32'h8000_0000, 32'h1, 32'h0);
    wait_done();
    chk("sovf_lat",    64'(cyc), 64'(34));
    chk("sovf_result", 64'(bus.Result), 64'(32'h7FFF_FFFF));
    chk("sovf_nzvc",   64'(nzvc()), 64'(4'b0010));

    // UDIV by zero
    start_op(OP_UDIV, 32'd55, 32'h0, 32'h0);
    wait_done();
    chk("dz_lat",    64'(cyc), 64'(2));
    chk("dz_flag",   64'(bus.Div_Zero), 64'(1));
    chk("dz_result", 64'(bus.Result), 64'(0));
    chk("dz_nzvc",   64'(nzvc()), 64'(4'b0010));
    tick();
    chk("dz_pulse",  64'({bus.Done, bus.Div_Zero}), 64'(0));

    // Start while busy is ignored
    start_op(OP_UMUL, 32'd7, 32'd6, 32'h0);
    tick();  tick();
    bus.Start = 1'b1;  bus.Opcode = OP_SMULCC;  bus.Operand1 = 32'hFFFF_FFFF;  bus.Operand2 = 32'h3;
    tick();
    bus.Start = 1'b0;
    wait_done();
    chk("busy_lat",    64'(cyc), 64'(mul_lat(32'd6)));
    chk("busy_result", 64'(bus.Result), 64'(32'd42));
    chk("busy_yout",   64'(bus.Y_Out), 64'(0));
    chk("busy_ccw",    64'(bus.CC_Write), 64'(0));
    tick();

    // Reset in cycle 10 of a multiply aborts it
    start_op(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    while (cyc < 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",   64'(bus.Busy), 64'(0));
    chk("abort_done",   64'(bus.Done), 64'(0));
    chk("abort_result", 64'(bus.Result), 64'(0));
    chk("abort_yout",   64'(bus.Y_Out), 64'(0));
    dn = 0;
    repeat (40) begin
      tick();
      if (bus.Done === 1'b1) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'(0));

    // Start in the Done cycle is accepted
    start_op(OP_UMUL, 32'd3, 32'd4, 32'h0);
    wait_done();
    chk("b2b_first", 64'(bus.Result), 64'(32'd12));
    start_op(OP_UMULCC, 32'd5, 32'd5, 32'h0);
    chk("b2b_busy", 64'(bus.Busy), 64'(1));
    wait_done();
    chk("b2b_lat",    64'(cyc), 64'(mul_lat(32'd5)));
    chk("b2b_result", 64'(bus.Result), 64'(32'd25));
    chk("b2b_ccw",    64'(bus.CC_Write), 64'(1));
    chk("b2b_nzvc",   64'(nzvc()), 64'(4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sparc_muldiv_unit.md
Name: sparc_muldiv_unit

Overview:
- Iterative multiply/divide unit for the SPARC integer datapath. Sits beside the combinational ALU.
- Executes UMUL/SMUL/UDIV/SDIV and their cc forms, one bit per clock.
- Produces Result, the Y-register high word and NZVC codes.
- Start/Done handshake, so the pipeline can stall on multi-cycle ops.

Parameters:
- WIDTH, 32: operand/result width. Products and dividends are 2*WIDTH.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  reset is synchronous and active-high
- Start  input  1  request; accepted only when Busy=0 and Opcode is supported
- Opcode  input  6  SPARC op3: 001010 UMUL, 001011 SMUL, 001110 UDIV, 001111 SDIV; cc forms 011010/011011/011110/011111
- Operand1  input  WIDTH  multiplicand / dividend low word
- Operand2  input  WIDTH  multiplier / divisor
- Y_In  input  WIDTH  dividend high word (divide only)
- Busy  output  1  high from the cycle after acceptance until Done
- Done  output  1  one-cycle pulse; Result/flags valid and held until next Done
- Result  output  WIDTH  product low word / quotient
- Y_Out  output  WIDTH  product high word
- Y_Write  output  1  pulses with Done for multiplies only
- Div_Zero  output  1  pulses with Done when the divisor is 0
- Condition_N, Condition_Z, Condition_V, Condition_C  output  1 each  cc outputs
- CC_Write  output  1  pulses with Done for cc opcodes only

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counter 0. Reset mid-operation aborts the op; no Done is issued.
- Operands and opcode are latched at acceptance. Later input changes have no effect.
- States and transitions:
  - IDLE: on accepted Start, go to RUN, or to FIN for divide-by-zero or pre-detected divide overflow.
  - RUN: WIDTH iterations.
  - FIN: sign-correct, saturate, set flags, pulse Done; then IDLE.
- Latency: normal Done in cycle WIDTH+2 after the Start cycle. Fast-path Done in cycle 2.
- Start while Busy, or with an unsupported opcode, is ignored with no side effects.
- A back-to-back Start in the Done cycle is accepted.
- Multiply:
  - Shift-add on operand magnitudes.
  - Signed: negate the 2*WIDTH product if the operand signs differ.
  - {Y_Out, Result} = product.
- Divide:
  - Dividend {Y_In, Operand1}; restoring division on magnitudes; quotient truncates toward zero.
  - Unsigned overflow when Y_In >= Operand2: fast path, Result = all ones, V=1.
  - Signed: overflow when high magnitude >= divisor magnitude, or when the final quotient exceeds the signed range. Saturate to 0x7FFF_FFFF (positive) or 0x8000_0000 (negative), V=1.
  - Divisor 0: fast path, Result 0, Div_Zero=1, V=0.
  - Remainder is discarded; Y_Write stays 0.
- Flags, updated only on cc ops:
  - N = Result[WIDTH-1]; Z = (Result==0); C = 0.
  - V = 0 for multiply, overflow for divide.
  - Non-cc ops hold the previous flag values.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: multiply leaves RUN as soon as the remaining shifted multiplier magnitude is 0. Done arrives in cycle k+2, where k = index of highest set multiplier-magnitude bit + 1 (k=0 for zero multiplier). Results are identical.
- Undefined: fixed WIDTH+2 latency for every non-fast-path op.

Decomposition:
- Package sparc_muldiv_pkg holds:
  - op3 opcode localparams;
  - FSM state encoding (IDLE, RUN, FIN);
  - saturation constants (functions of WIDTH).
- One sub-module, muldiv_sign_fix: combinational magnitude/negate helper shared by input conditioning and FIN.

Test Plan:
1. UMUL 0xFFFFFFFF * 0xFFFFFFFF → Result 0x00000001, Y_Out 0xFFFFFFFE, Y_Write=1, Done in cycle 34, CC_Write=0.
2. SMULcc 0xFFFFFFFD (-3) * 0x00000005 → Result 0xFFFFFFF1, Y_Out 0xFFFFFFFF, NZVC 1000.
3. UDIVcc Y_In=0, 100 / 7 → Result 0x0000000E, NZVC 0000, Y_Write=0. Then SDIV Y_In=0xFFFFFFFF, 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
4. UDIVcc Y_In=1, Operand1=0, Operand2=1 → fast path, Done in cycle 2, Result 0xFFFFFFFF, V=1. Then SDIVcc Y_In=0, 0x80000000 / 1 → Result 0x7FFFFFFF, V=1.
5. UDIV with Operand2=0 → Done in cycle 2, Div_Zero=1, Result 0.
6. Handshake and reset:
   - Start pulsed during Busy is ignored and the original result is unchanged.
   - Reset asserted at cycle 10 of a multiply → Busy=0, no Done, outputs 0.
   - A Start in the Done cycle is accepted.
